// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - sequencing FSM for the multicycle MIPS core with a shared memory port
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       signext,
  output logic       shiftl16,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_JR     = 6'b001000;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BRANCH  = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11,
    JALST   = 4'd12,
    JRST    = 4'd13
  } state_t;

  state_t     state_q, state_d;
  logic       rfunct_ok;
  logic [2:0] rfunct_alu;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // ALU operation for the supported R-type functs; JR is handled separately
  always_comb begin
    rfunct_ok  = 1'b1;
    rfunct_alu = 3'b010;
    case (funct)
      6'b100000, 6'b100001: rfunct_alu = 3'b010;
      6'b100010, 6'b100011: rfunct_alu = 3'b110;
      6'b100100:            rfunct_alu = 3'b000;
      6'b100101:            rfunct_alu = 3'b001;
      6'b101010, 6'b101011: rfunct_alu = 3'b111;
      default:              rfunct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = FETCH;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    signext    = 1'b0;
    shiftl16   = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcen    = memready;
        state_d = memready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        signext = 1'b1;
        case (op)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_R: begin
            if (funct == F_JR)  state_d = JRST;
            else if (rfunct_ok) state_d = RTYPEEX;
            else                illegal = 1'b1;
          end
          OP_BEQ, OP_BNE:   state_d = BRANCH;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_d = IMMEX;
          OP_J:             state_d = JUMP;
          OP_JAL:           state_d = JALST;
          default:          illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        signext = 1'b1;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
      end
      // the strobe stays up across wait cycles
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = memready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rfunct_alu;
        state_d    = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = (op == OP_BEQ) ? zero : ~zero;
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = IMMWB;
        case (op)
          OP_ORI:  alucontrol = 3'b001;
          OP_LUI:  shiftl16   = 1'b1;
          default: signext    = 1'b1;
        endcase
      end
      IMMWB:   regwrite = 1'b1;
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      // $31 takes the PC, which already holds PC+4 from FETCH
      JALST: begin
        pcsrc    = 2'b10;
        pcen     = 1'b1;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
      end
      JRST: begin
        pcsrc = 2'b11;
        pcen  = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    if (reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
